// File: rtl/day_month_counter.sv
// rtl/day_month_counter.sv - day-of-month/month calendar counter with manual set and year carry
// Optional macro DATE_LEAP_YEAR_EN: February follows the Gregorian leap rule (else always 28 days).
module day_month_counter #(
    parameter logic [4:0] RST_DAY   = 5'd1,
    parameter logic [3:0] RST_MONTH = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        day_tick,
    input  logic        manual_set,
    input  logic        up,
    input  logic        down,
    input  logic        sel,
    input  logic [13:0] year,
    output logic [4:0]  day,
    output logic [3:0]  month,
    output logic        year_carry
);

    logic leap;

`ifdef DATE_LEAP_YEAR_EN
    assign leap = ((year[1:0] == 2'b00) && ((year % 14'd100) != 14'd0))
               || ((year % 14'd400) == 14'd0);
`else
    logic unused_year;
    assign leap        = 1'b0;
    assign unused_year = ^year;
`endif

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
            4'd2:                    month_len = lp ? 5'd29 : 5'd28;
            default:                 month_len = 5'd31;
        endcase
    endfunction

    logic [4:0] mdays;
    logic [4:0] new_len;
    logic [4:0] day_n;
    logic [3:0] month_n;
    logic       carry_n;
    logic       bad_month;

    assign mdays     = month_len(month, leap);
    assign bad_month = (month == 4'd0) || (month > 4'd12);

    always_comb begin
        day_n   = day;
        month_n = month;
        carry_n = 1'b0;
        new_len = mdays;
        if (bad_month || (day == 5'd0)) begin
            if (bad_month)
                month_n = 4'd1;
            if (day == 5'd0)
                day_n = 5'd1;
        end else if (manual_set) begin
            // day_tick is dropped here; up beats down
            if (up || down) begin
                if (!sel) begin
                    if (up)
                        day_n = (day >= mdays) ? 5'd1 : day + 5'd1;
                    else
                        day_n = (day == 5'd1) ? mdays : day - 5'd1;
                end else begin
                    if (up)
                        month_n = (month == 4'd12) ? 4'd1 : month + 4'd1;
                    else
                        month_n = (month == 4'd1) ? 4'd12 : month - 4'd1;
                    new_len = month_len(month_n, leap);
                    if (day > new_len)
                        day_n = new_len;
                end
            end
        end else if (day_tick) begin
            if (day < mdays) begin
                day_n = day + 5'd1;
            end else begin
                day_n = 5'd1;
                if (month == 4'd12) begin
                    month_n = 4'd1;
                    carry_n = 1'b1;
                end else begin
                    month_n = month + 4'd1;
                end
            end
        end else if (day > mdays) begin
            // year changed under a Feb 29
            day_n = mdays;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            day        <= RST_DAY;
            month      <= RST_MONTH;
            year_carry <= 1'b0;
        end else begin
            day        <= day_n;
            month      <= month_n;
            year_carry <= carry_n;
        end
    end

endmodule

// File: tb/tb_day_month_counter.sv
// tb/tb_day_month_counter.sv - scoreboard bench for day_month_counter
module tb_day_month_counter;

`ifdef DATE_LEAP_YEAR_EN
    localparam bit LEAP = 1'b1;
`else
    localparam bit LEAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst = 1'b0;
    logic        day_tick = 1'b0;
    logic        manual_set = 1'b0;
    logic        up = 1'b0;
    logic        down = 1'b0;
    logic        sel = 1'b0;
    logic [13:0] year = 14'd2025;
    logic [4:0]  day;
    logic [3:0]  month;
    logic        year_carry;

    day_month_counter dut (
        .clk        (clk),
        .rst        (rst),
        .day_tick   (day_tick),
        .manual_set (manual_set),
        .up         (up),
        .down       (down),
        .sel        (sel),
        .year       (year),
        .day        (day),
        .month      (month),
        .year_carry (year_carry)
    );

    always #5 if (clk_en) clk = ~clk;

    typedef struct packed {
        logic [4:0] d;
        logic [3:0] m;
        logic       c;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_pass = 0;
    int    n_total = 0;

    task automatic check(input string name, input logic [4:0] ad, input logic [3:0] am,
                         input logic ac, input logic [4:0] ed, input logic [3:0] em,
                         input logic ec);
        n_total++;
        if (ad === ed && am === em && ac === ec)
            n_pass++;
        else
            $display("FAIL %s: got day=%0d month=%0d carry=%0d, expected day=%0d month=%0d carry=%0d",
                     name, ad, am, ac, ed, em, ec);
    endtask

    // monitor: one registered result per clock
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, day, month, year_carry, e.d, e.m, e.c);
            end
        end
    end

    task automatic step(input logic ms, input logic tk, input logic u, input logic dn,
                        input logic s, input logic [4:0] ed, input logic [3:0] em,
                        input logic ec, input string name);
        exp_t e;
        @(negedge clk);
        #1;
        manual_set = ms; day_tick = tk; up = u; down = dn; sel = s;
        e.d = ed; e.m = em; e.c = ec;
        exp_q.push_back(e);
        name_q.push_back(name);
        @(posedge clk);
        #1;
        manual_set = 1'b0; day_tick = 1'b0; up = 1'b0; down = 1'b0; sel = 1'b0;
    endtask

    task automatic pulse_reset(input string name);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check(name, day, month, year_carry, 5'd1, 4'd1, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        // async reset with the clock stopped
        #1 rst = 1'b1;
        #1 check("reset_no_clk", day, month, year_carry, 5'd1, 4'd1, 1'b0);
        #1 rst = 1'b0;
        clk_en = 1'b1;

        step(0, 0, 0, 0, 0, 5'd1,  4'd1,  1'b0, "idle_after_reset");
        step(1, 0, 0, 1, 1, 5'd1,  4'd12, 1'b0, "month_down_wrap");
        step(1, 0, 0, 1, 0, 5'd31, 4'd12, 1'b0, "day_down_wrap_dec");
        step(0, 1, 0, 0, 0, 5'd1,  4'd1,  1'b1, "year_rollover");
        step(0, 0, 0, 0, 0, 5'd1,  4'd1,  1'b0, "carry_one_cycle");

        // manual month change clamps day
        step(1, 0, 0, 1, 0, 5'd31, 4'd1,  1'b0, "jan31_set");
        step(1, 0, 1, 0, 1, 5'd28, 4'd2,  1'b0, "jan31_up_feb_clamp");
        step(1, 0, 0, 1, 1, 5'd28, 4'd1,  1'b0, "feb_down_jan");
        step(1, 0, 0, 1, 1, 5'd28, 4'd12, 1'b0, "jan_down_dec");
        step(1, 0, 1, 0, 1, 5'd28, 4'd1,  1'b0, "dec_up_wrap_jan");
        step(1, 0, 1, 0, 1, 5'd28, 4'd2,  1'b0, "feb28_set");

        // leap February at 2028
        year = 14'd2028;
        step(0, 1, 0, 0, 0, LEAP ? 5'd29 : 5'd1, LEAP ? 4'd2 : 4'd3, 1'b0, "tick_feb28_2028");
        step(0, 1, 0, 0, 0, LEAP ? 5'd1 : 5'd2,  4'd3,                1'b0, "tick_second_2028");

        // century non-leap 2100
        year = 14'd2100;
        pulse_reset("reset_2100");
        step(1, 0, 0, 1, 0, 5'd31, 4'd1, 1'b0, "jan31_2100");
        step(1, 0, 1, 0, 1, 5'd28, 4'd2, 1'b0, "feb_clamp_2100");
        step(0, 1, 0, 0, 0, 5'd1,  4'd3, 1'b0, "tick_feb28_2100");

        // 400-year leap 2400
        year = 14'd2400;
        pulse_reset("reset_2400");
        step(1, 0, 0, 1, 0, 5'd31, 4'd1, 1'b0, "jan31_2400");
        step(1, 0, 1, 0, 1, LEAP ? 5'd29 : 5'd28, 4'd2, 1'b0, "feb_clamp_2400");
        step(0, 1, 0, 0, 0, LEAP ? 5'd1 : 5'd1,   4'd3, 1'b0, "tick_feb_2400");

        // year change clamps Feb 29 down
        year = 14'd2028;
        pulse_reset("reset_2028");
        step(1, 0, 0, 1, 0, 5'd31, 4'd1, 1'b0, "jan31_2028");
        step(1, 0, 1, 0, 1, LEAP ? 5'd29 : 5'd28, 4'd2, 1'b0, "feb_clamp_2028");
        year = 14'd2029;
        step(0, 0, 0, 0, 0, 5'd28, 4'd2, 1'b0, "year_change_clamp");

        // manual day priority in April
        year = 14'd2025;
        pulse_reset("reset_apr");
        step(1, 0, 1, 0, 1, 5'd1,  4'd2, 1'b0, "to_feb");
        step(1, 0, 1, 0, 1, 5'd1,  4'd3, 1'b0, "to_mar");
        step(1, 0, 1, 0, 1, 5'd1,  4'd4, 1'b0, "to_apr");
        step(1, 0, 0, 1, 0, 5'd30, 4'd4, 1'b0, "apr_day_down_wrap");
        step(1, 1, 1, 1, 0, 5'd1,  4'd4, 1'b0, "up_wins_tick_ignored");
        step(0, 1, 0, 0, 0, 5'd2,  4'd4, 1'b0, "plain_tick");

        // tick dropped in manual mode at Dec 31
        pulse_reset("reset_dec");
        step(1, 0, 0, 1, 1, 5'd1,  4'd12, 1'b0, "dec1");
        step(1, 0, 0, 1, 0, 5'd31, 4'd12, 1'b0, "dec31");
        step(1, 1, 0, 0, 0, 5'd31, 4'd12, 1'b0, "manual_blocks_tick");
        step(0, 0, 0, 0, 0, 5'd31, 4'd12, 1'b0, "hold_dec31");

        // reset during carry cancels it
        step(0, 1, 0, 0, 0, 5'd1,  4'd1,  1'b1, "rollover_again");
        pulse_reset("reset_cancels_carry");

        repeat (3) @(negedge clk);
        n_total++;
        if (exp_q.size() == 0)
            n_pass++;
        else
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
